interrupt_sequencer: RTL
========================

// Module: interrupt_sequencer
// PURPOSE
//   Arbitrates RESET, NMI, IRQ and BRK requests and runs the 7-cycle interrupt sequence.
//   Emits per-cycle strobes that the control-flag decoder ORs into the internal dataflow flags.
//   These strobes cover the stack pushes of PCH/PCL/PSR, SP decrement, vector fetch from $FFxx and I-flag set.
//   Sits beside the instruction decoder. It owns the control flags only while busy=1.
// PARAMETERS
//   SYNC_STAGES  2  flops in the synchronizer on the nmi_n/irq_n pins (min 2)
// PORTS
//   clk           in   1  core clock; all state updates on rising edge
//   rst           in   1  synchronous, active-high reset
//   nmi_n         in   1  async NMI pin, falling-edge triggered
//   irq_n         in   1  async IRQ pin, level low
//   brk_req       in   1  decoder has fetched a BRK opcode (one-cycle pulse)
//   instr_done    in   1  instruction boundary pulse from decoder
//   psr_i         in   1  PSR interrupt-disable bit
//   busy          out  1  sequence active; decoder flags suppressed
//   step          out  3  current sequence cycle 1..7, 0 when idle
//   push_sel      out  2  00 none, 01 PCH, 10 PCL, 11 PSR onto DB->DOR
//   stack_write   out  1  write DOR to $01:SP this cycle
//   sp_dec        out  1  decrement SP this cycle
//   vec_adl       out  8  vector low byte: FA NMI, FC RESET, FE IRQ/BRK (+1 on hi fetch)
//   vec_fetch_lo  out  1  load PCL from external DB
//   vec_fetch_hi  out  1  load PCH from external DB
//   set_i         out  1  set PSR I flag
//   psr_b         out  1  B bit value for the pushed PSR (1 only for BRK)
//   seq_done      out  1  one-cycle pulse in the cycle after step 7
//   nmi_ack       out  1  one-cycle pulse when the NMI latch is consumed
// BEHAVIOUR
//   Reset: all outputs 0, nmi latch 0, synchronizers 1, state IDLE, rst_pend=1.
//   After rst falls, the RESET sequence starts on the first clock (no instr_done needed).
//   NMI: a 1->0 transition on the synchronized nmi_n sets nmi latch. The latch holds until it is consumed.
//     Latency from pin to latch is SYNC_STAGES+1 cycles.
//   IRQ is pending while synchronized irq_n=0 and psr_i=0. It is sampled only at instr_done.
//   Arbitration runs at instr_done (or immediately for rst_pend). Priority: RESET > NMI > BRK > IRQ.
//   A brk_req coinciding with the IRQ pending condition takes BRK (psr_b=1, B bit set).
//   FSM: IDLE -> S1..S7 -> DONE -> IDLE.
//     S1: dummy read at PC; no strobes.
//     S2: dummy read; PC increments for BRK only.
//     S3: push_sel=PCH, sp_dec=1, stack_write=1.
//     S4: push_sel=PCL, sp_dec=1, stack_write=1.
//     S5: push_sel=PSR, sp_dec=1, stack_write=1.
//     S6: vec_adl=base, vec_fetch_lo=1, set_i=1.
//     S7: vec_adl=base+1, vec_fetch_hi=1.
//     DONE: seq_done=1, busy=0, step=0.
//   RESET source: stack_write forced 0 in S3-S5 and sp_dec still 1, so SP ends at SP-3. psr_b=0.
//   NMI consumption: nmi latch clears and nmi_ack pulses in S5.
//     An NMI edge arriving during S5-S7 re-sets the latch and is served at the next arbitration.
//   rst asserted mid-sequence aborts immediately: outputs go to their reset values, then RESET runs.
//   Outputs are registered. Strobes are valid for the whole of the cycle whose step they label.
// CONFIGURATION
//   INT_SEQ_NMI_HIJACK_EN defined:
//     NMI latched at or before S4 of a BRK/IRQ sequence switches vec_adl to FA/FB for S6/S7.
//     The pushes are unchanged; psr_b stays 1 for a hijacked BRK.
//     nmi_ack pulses in S5 and the NMI is not served again.
//   Macro undefined: the vector is fixed at arbitration. The NMI waits for the next sequence.
// STRUCTURE
//   Package interrupt_pkg:
//     typedef enum int_src_t {SRC_RESET, SRC_NMI, SRC_BRK, SRC_IRQ}
//     typedef enum seq_state_t {IDLE, S1..S7, DONE}
//     push_sel constants
//     VEC_NMI=8'hFA, VEC_RESET=8'hFC, VEC_IRQ=8'hFE
//   Sub-module sync_edge_detect (SYNC_STAGES): synchronizer plus falling-edge pulse.
//     One instance for nmi_n; the irq_n instance uses the level output only.
// TESTING
//   Cold reset:
//     rst high 3 cycles, then low -> busy=1 next cycle.
//     S3-S5 have stack_write=0 and sp_dec=1.
//     S6 vec_adl=FC; S7 vec_adl=FD.
//     seq_done pulses exactly 8 cycles after rst falls.
//   IRQ masking:
//     irq_n=0 with psr_i=1, instr_done pulses -> busy stays 0.
//     Set psr_i=0, next instr_done -> sequence with vec_adl FE/FF and psr_b=0.
//   BRK vs IRQ:
//     brk_req and instr_done with irq pending -> psr_b=1 in S5, vec FE/FF, PC increments in S2.
//     The IRQ is served on the following instr_done.
//   NMI edge:
//     nmi_n pulses low for 1 cycle then stays high -> latch sets after SYNC_STAGES+1 cycles.
//     Next instr_done gives vec FA/FB; nmi_ack pulses in S5.
//     nmi_n held low afterwards triggers no second sequence.
//   Hijack:
//     NMI edge latched during S3 of a BRK sequence.
//     With INT_SEQ_NMI_HIJACK_EN: S6/S7 show FA/FB, psr_b=1.
//     Without the macro: FE/FF, then the NMI sequence follows the next instr_done.
//   Reset mid-sequence:
//     rst high in S4 of an IRQ sequence -> all outputs 0 next cycle.
//     After release, a full RESET sequence runs with vec FC/FD.

Source files
------------

// File: rtl/interrupt_pkg.sv
// interrupt_pkg: shared types and constants for the interrupt sequencer.
// Sources, sequence states, push selects, vectors and the output bundle.
package interrupt_pkg;

  typedef enum logic [1:0] {
    SRC_RESET,
    SRC_NMI,
    SRC_BRK,
    SRC_IRQ
  } int_src_t;

  typedef enum logic [3:0] {
    IDLE,
    S1,
    S2,
    S3,
    S4,
    S5,
    S6,
    S7,
    DONE
  } seq_state_t;

  localparam logic [1:0] PUSH_NONE = 2'b00;
  localparam logic [1:0] PUSH_PCH  = 2'b01;
  localparam logic [1:0] PUSH_PCL  = 2'b10;
  localparam logic [1:0] PUSH_PSR  = 2'b11;

  localparam logic [7:0] VEC_NMI   = 8'hFA;
  localparam logic [7:0] VEC_RESET = 8'hFC;
  localparam logic [7:0] VEC_IRQ   = 8'hFE;

  typedef struct packed {
    logic       busy;
    logic [2:0] step;
    logic [1:0] push_sel;
    logic       stack_write;
    logic       sp_dec;
    logic [7:0] vec_adl;
    logic       vec_fetch_lo;
    logic       vec_fetch_hi;
    logic       set_i;
    logic       psr_b;
    logic       seq_done;
    logic       nmi_ack;
  } seq_out_t;

  function automatic logic [7:0] src_vec(
    input int_src_t s
  );
    if (s == SRC_RESET) return VEC_RESET;
    if (s == SRC_NMI) return VEC_NMI;
    return VEC_IRQ;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop pin synchronizer with falling-edge pulse.
// Synchronizer and edge history reset to 1 (pin idle high).
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // shift the pin through the synchronizer, keep last synced value
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign fall  = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: RESET/NMI/BRK/IRQ arbitration and 7-cycle sequence.
// Define INT_SEQ_NMI_HIJACK_EN to let a late NMI redirect a BRK/IRQ vector.
module interrupt_sequencer
  import interrupt_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       brk_req,
  input  logic       instr_done,
  input  logic       psr_i,
  output logic       busy,
  output logic [2:0] step,
  output logic [1:0] push_sel,
  output logic       stack_write,
  output logic       sp_dec,
  output logic [7:0] vec_adl,
  output logic       vec_fetch_lo,
  output logic       vec_fetch_hi,
  output logic       set_i,
  output logic       psr_b,
  output logic       seq_done,
  output logic       nmi_ack
);

  logic       nmi_fall;
  logic       irq_lvl;
  logic       irq_pend;
  logic       nmi_q;
  logic       rst_pend_q;
  logic       nmi_take;
  seq_state_t state_q, state_d;
  int_src_t   src_q, src_d;
  logic [7:0] vbase_q, vbase_d;
  seq_out_t   out_q, out_d;

  sync_edge_detect #(
    .STAGES(SYNC_STAGES)
  ) u_nmi (
    .clk  (clk),
    .rst  (rst),
    .din  (nmi_n),
    .level(),
    .fall (nmi_fall)
  );

  sync_edge_detect #(
    .STAGES(SYNC_STAGES)
  ) u_irq (
    .clk  (clk),
    .rst  (rst),
    .din  (irq_n),
    .level(irq_lvl),
    .fall ()
  );

  assign irq_pend = ~irq_lvl & ~psr_i;

  // arbitration, step sequencing and NMI consumption
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    vbase_d  = vbase_q;
    nmi_take = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rst_pend_q) begin
          state_d = S1;
          src_d   = SRC_RESET;
        end else if (instr_done) begin
          if (nmi_q) begin
            state_d = S1;
            src_d   = SRC_NMI;
          end else if (brk_req) begin
            state_d = S1;
            src_d   = SRC_BRK;
          end else if (irq_pend) begin
            state_d = S1;
            src_d   = SRC_IRQ;
          end
        end
        vbase_d = src_vec(src_d);
      end
      S1: state_d = S2;
      S2: state_d = S3;
      S3: state_d = S4;
      S4: begin
        state_d = S5;
        if (nmi_q) begin
          if (src_q == SRC_NMI) begin
            nmi_take = 1'b1;
`ifdef INT_SEQ_NMI_HIJACK_EN
          end else if (src_q != SRC_RESET) begin
            nmi_take = 1'b1;
            vbase_d  = VEC_NMI;
`endif
          end
        end
      end
      S5: state_d = S6;
      S6: state_d = S7;
      S7: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // strobes for the step being entered, registered below
  always_comb begin
    out_d          = '0;
    out_d.push_sel = PUSH_NONE;
    unique case (state_d)
      S1: begin
        out_d.busy = 1'b1;
        out_d.step = 3'd1;
      end
      S2: begin
        out_d.busy = 1'b1;
        out_d.step = 3'd2;
      end
      S3: begin
        out_d.busy        = 1'b1;
        out_d.step        = 3'd3;
        out_d.push_sel    = PUSH_PCH;
        out_d.sp_dec      = 1'b1;
        out_d.stack_write = (src_d != SRC_RESET);
      end
      S4: begin
        out_d.busy        = 1'b1;
        out_d.step        = 3'd4;
        out_d.push_sel    = PUSH_PCL;
        out_d.sp_dec      = 1'b1;
        out_d.stack_write = (src_d != SRC_RESET);
      end
      S5: begin
        out_d.busy        = 1'b1;
        out_d.step        = 3'd5;
        out_d.push_sel    = PUSH_PSR;
        out_d.sp_dec      = 1'b1;
        out_d.stack_write = (src_d != SRC_RESET);
        out_d.psr_b       = (src_d == SRC_BRK);
        out_d.nmi_ack     = nmi_take;
      end
      S6: begin
        out_d.busy         = 1'b1;
        out_d.step         = 3'd6;
        out_d.vec_adl      = vbase_d;
        out_d.vec_fetch_lo = 1'b1;
        out_d.set_i        = 1'b1;
      end
      S7: begin
        out_d.busy         = 1'b1;
        out_d.step         = 3'd7;
        out_d.vec_adl      = vbase_d + 8'd1;
        out_d.vec_fetch_hi = 1'b1;
      end
      DONE: out_d.seq_done = 1'b1;
      default: ;
    endcase
  end

  // state, NMI latch, pending reset and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      src_q      <= SRC_RESET;
      vbase_q    <= VEC_RESET;
      rst_pend_q <= 1'b1;
      nmi_q      <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      vbase_q    <= vbase_d;
      rst_pend_q <= 1'b0;
      out_q      <= out_d;
      if (nmi_fall) begin
        nmi_q <= 1'b1;
      end else if (nmi_take) begin
        nmi_q <= 1'b0;
      end
    end
  end

  assign busy         = out_q.busy;
  assign step         = out_q.step;
  assign push_sel     = out_q.push_sel;
  assign stack_write  = out_q.stack_write;
  assign sp_dec       = out_q.sp_dec;
  assign vec_adl      = out_q.vec_adl;
  assign vec_fetch_lo = out_q.vec_fetch_lo;
  assign vec_fetch_hi = out_q.vec_fetch_hi;
  assign set_i        = out_q.set_i;
  assign psr_b        = out_q.psr_b;
  assign seq_done     = out_q.seq_done;
  assign nmi_ack      = out_q.nmi_ack;

endmodule
